branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 Z_in  input  3  ALU status: bit0 zero (Z), bit1 negative (N), bit2 overflow (V).
REQ-005 loads  input  1  when high at a clk edge, Z_in SHALL be captured into the status register.
REQ-006 br_valid  input  1  branch request valid.
REQ-007 br_ready  output  1  branch request accepted when br_valid and br_ready are both high at a clk edge.
REQ-008 cond  input  3  branch condition: 000 B, 001 BEQ, 010 BNE, 011 BLT, 100 BLE, 101-111 reserved.
REQ-009 imm8  input  8  signed two's-complement branch offset.
REQ-010 pc_in  input  9  PC of the instruction after the branch (already incremented).
REQ-011 pc_next  output  9  target PC; valid while load_pc is high.
REQ-012 load_pc  output  1  one-cycle pulse that loads pc_next into the PC.
REQ-013 taken  output  1  high with load_pc when the branch is taken.
REQ-014 status  output  3  current status register contents {V,N,Z}.

Function
REQ-015 Status register SHALL load Z_in on every clk edge where loads=1 and hold otherwise, independent of FSM state.
REQ-016 FSM states SHALL be IDLE, EVAL and COMMIT; br_ready=1 only in IDLE.
REQ-017 On the accept edge the FSM SHALL move IDLE->EVAL and capture cond, imm8, pc_in, and the status value present before that edge.
REQ-018 If loads and accept coincide, evaluation SHALL use the pre-edge (old) status value; the register still updates.
REQ-019 EVAL->COMMIT SHALL occur unconditionally on the next edge and register pc_next and taken.
REQ-020 In COMMIT, load_pc=1 for exactly one cycle; COMMIT->IDLE on the next edge; accept-to-load_pc latency is 2 cycles; throughput is one branch per 3 cycles.
REQ-021 Taken conditions SHALL be: B always; BEQ Z=1; BNE Z=0; BLT N!=V; BLE (N!=V) or Z=1.
REQ-022 When taken, pc_next SHALL equal pc_in + sign-extended imm8, truncated to 9 bits (wrap-around modulo 512, no error).
REQ-023 When not taken, pc_next SHALL equal pc_in and taken=0; load_pc still pulses.
REQ-024 Reserved cond codes SHALL behave as not taken.
REQ-025 br_valid outside IDLE SHALL be ignored; the requester holds it until accepted.

Reset
REQ-026 Reset SHALL force state=IDLE, status=000, pc_next=0, taken=0, load_pc=0 and clear all captured fields; br_ready=1 after deassertion.
REQ-027 Reset asserted in EVAL or COMMIT SHALL abort the branch with no load_pc pulse.

Configuration
REQ-028 Macro BRANCH_UNIT_LINK_EN: when defined, cond 111 = BL (always taken) and ports link_out (output 16, {7'b0, captured pc_in}) and link_we (output 1, pulses with load_pc) SHALL exist; both reset to 0.
REQ-029 Without BRANCH_UNIT_LINK_EN, the link ports SHALL be absent and 111 SHALL remain reserved (not taken).

Structure
REQ-030 A shared package simplerisc_pkg SHALL hold the cond encodings, FSM state enum, PC_W=9 and the status bit indices.
REQ-031 A combinational sub-module cond_eval (cond, status -> taken) SHALL implement REQ-021/024.

Verification
REQ-032 loads=1, Z_in=001; then BEQ, pc_in=0x010, imm8=0x05 -> load_pc 2 cycles after accept, taken=1, pc_next=0x015.
REQ-033 status=000, BLT, pc_in=0x020, imm8=0xFE -> taken=0, pc_next=0x020; then status=010 (N=1,V=0), same request -> taken=1, pc_next=0x01E.
REQ-034 pc_in=0x1FF, B, imm8=0x02 -> pc_next=0x001 (wrap); pc_in=0x000, imm8=0x80 -> pc_next=0x180.
REQ-035 Status Z=0, then loads=1 with Z_in=001 on the same edge as a BEQ accept -> taken=0, status reads 001 afterwards.
REQ-036 Reset pulsed in EVAL -> no load_pc, status=000, br_ready=1; with LINK_EN, BL pc_in=0x044 -> link_we=1, link_out=0x0044, taken=1.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// -----------------------------------------------------------------------------
// simplerisc_pkg -- shared definitions for the SimpleRISC branch path.
//
// Contents:
//   PC_W, IMM_W, STATUS_W, COND_W, LINK_W : datapath widths
//   STATUS_Z / STATUS_N / STATUS_V        : bit indices inside the status word
//   cond_e                                : branch condition encodings
//   state_e                               : branch_unit FSM states
//   branch_target()                       : PC + sign-extended offset, mod 2^PC_W
//
// Configuration macro: BRANCH_UNIT_LINK_EN (COND_BL is only meaningful when the
// macro is defined; otherwise code 3'b111 decodes as reserved).
// -----------------------------------------------------------------------------
package simplerisc_pkg;

  localparam int PC_W     = 9;
  localparam int IMM_W    = 8;
  localparam int STATUS_W = 3;
  localparam int COND_W   = 3;
  localparam int LINK_W   = 16;

  // Status word layout: {V, N, Z}
  localparam int STATUS_Z = 0;
  localparam int STATUS_N = 1;
  localparam int STATUS_V = 2;

  typedef enum logic [COND_W-1:0] {
    COND_B   = 3'b000,
    COND_BEQ = 3'b001,
    COND_BNE = 3'b010,
    COND_BLT = 3'b011,
    COND_BLE = 3'b100,
    COND_BL  = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Target address: the offset is sign-extended to PC width and the sum simply
  // wraps, so branches across address 0 / 511 need no special handling.
  function automatic logic [PC_W-1:0] branch_target(
    input logic [PC_W-1:0]  pc,
    input logic [IMM_W-1:0] imm
  );
    logic [PC_W-1:0] imm_ext;
    imm_ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    return pc + imm_ext;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval -- combinational branch-condition evaluator.
//
// Ports:
//   cond   in  3  branch condition code (see simplerisc_pkg::cond_e)
//   status in  3  status flags {V, N, Z}
//   taken  out 1  1 when the branch should be taken
//
// Configuration macro: BRANCH_UNIT_LINK_EN -- when defined, code 3'b111 is BL
// (always taken); otherwise it is reserved and never taken. Codes 101/110 are
// always reserved and never taken.
// -----------------------------------------------------------------------------
module cond_eval
  import simplerisc_pkg::*;
(
  input  logic [COND_W-1:0]   cond,
  input  logic [STATUS_W-1:0] status,
  output logic                taken
);

  logic flag_z;
  logic flag_lt;

  assign flag_z  = status[STATUS_Z];
  // Signed less-than after a compare: negative result unless it overflowed.
  assign flag_lt = status[STATUS_N] ^ status[STATUS_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_B:   taken = 1'b1;
      COND_BEQ: taken = flag_z;
      COND_BNE: taken = ~flag_z;
      COND_BLT: taken = flag_lt;
      COND_BLE: taken = flag_lt | flag_z;
`ifdef BRANCH_UNIT_LINK_EN
      COND_BL:  taken = 1'b1;
`endif
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit -- conditional branch resolution for the SimpleRISC core.
//
// A request is accepted in IDLE (br_valid & br_ready), its fields and the
// status value from before the accept edge are captured, the condition is
// resolved in EVAL, and the target is presented in COMMIT with a one-cycle
// load_pc pulse. Accept-to-load_pc latency is 2 cycles; one branch per 3.
//
// Ports:
//   clk       in  1   clock, rising edge
//   reset     in  1   asynchronous, active-high reset
//   Z_in      in  3   ALU flags {V, N, Z}
//   loads     in  1   load Z_in into the status register this edge
//   br_valid  in  1   branch request valid
//   br_ready  out 1   ready for a request (IDLE only)
//   cond      in  3   condition code
//   imm8      in  8   signed branch offset
//   pc_in     in  9   PC of the following instruction
//   pc_next   out 9   resolved PC, valid while load_pc is high
//   load_pc   out 1   one-cycle PC load strobe
//   taken     out 1   branch taken, valid with load_pc
//   status    out 3   status register {V, N, Z}
//   link_out  out 16  (BRANCH_UNIT_LINK_EN only) zero-extended captured pc_in
//   link_we   out 1   (BRANCH_UNIT_LINK_EN only) link write strobe for BL
//
// Configuration macro: BRANCH_UNIT_LINK_EN (adds BL and the link ports).
// -----------------------------------------------------------------------------
module branch_unit
  import simplerisc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [STATUS_W-1:0] Z_in,
  input  logic                loads,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [COND_W-1:0]   cond,
  input  logic [IMM_W-1:0]    imm8,
  input  logic [PC_W-1:0]     pc_in,
  output logic [PC_W-1:0]     pc_next,
  output logic                load_pc,
  output logic                taken,
  output logic [STATUS_W-1:0] status
`ifdef BRANCH_UNIT_LINK_EN
  ,
  output logic [LINK_W-1:0]   link_out,
  output logic                link_we
`endif
);

  state_e               state_reg;
  state_e               state_next;
  logic                 accept;

  logic [STATUS_W-1:0]  status_reg;
  logic [COND_W-1:0]    cond_reg;
  logic [IMM_W-1:0]     imm_reg;
  logic [PC_W-1:0]      pc_reg;
  logic [STATUS_W-1:0]  stat_cap_reg;

  logic [PC_W-1:0]      pc_next_reg;
  logic                 taken_reg;
  logic                 eval_taken;

  // ---------------------------------------------------------------------------
  // Status register: follows loads regardless of what the FSM is doing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_reg <= '0;
    end else if (loads) begin
      status_reg <= Z_in;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    br_ready   = 1'b0;
    load_pc    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        br_ready = 1'b1;
        if (br_valid) begin
          accept     = 1'b1;
          state_next = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        load_pc    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture. status_reg is sampled with the same edge that may also
  // load it, so a coincident loads never affects the branch being accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_reg     <= '0;
      imm_reg      <= '0;
      pc_reg       <= '0;
      stat_cap_reg <= '0;
    end else if (accept) begin
      cond_reg     <= cond;
      imm_reg      <= imm8;
      pc_reg       <= pc_in;
      stat_cap_reg <= status_reg;
    end
  end

  cond_eval u_cond_eval (
    .cond   (cond_reg),
    .status (stat_cap_reg),
    .taken  (eval_taken)
  );

  // ---------------------------------------------------------------------------
  // Result registers, written on the EVAL->COMMIT edge. They hold afterwards,
  // but are only meaningful while load_pc is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_next_reg <= '0;
      taken_reg   <= 1'b0;
    end else if (state_reg == ST_EVAL) begin
      taken_reg   <= eval_taken;
      pc_next_reg <= eval_taken ? branch_target(pc_reg, imm_reg) : pc_reg;
    end
  end

  assign pc_next = pc_next_reg;
  assign taken   = taken_reg;
  assign status  = status_reg;

`ifdef BRANCH_UNIT_LINK_EN
  // Return address is the captured pc_in; the link register is only written
  // for BL, in the same cycle the PC is loaded.
  assign link_out = {{(LINK_W-PC_W){1'b0}}, pc_reg};
  assign link_we  = load_pc && (cond_reg == COND_BL);
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_load_pc_single: assert property (
    @(posedge clk) disable iff (reset) load_pc |=> !load_pc
  );

  a_eval_to_commit: assert property (
    @(posedge clk) disable iff (reset) (state_reg == ST_EVAL) |=> (state_reg == ST_COMMIT)
  );

  a_ready_only_idle: assert property (
    @(posedge clk) disable iff (reset) br_ready |-> (state_reg == ST_IDLE)
  );

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit -- scoreboard bench for branch_unit.
// Stimulus pushes the expected {taken, pc_next, accept cycle} for each branch;
// a monitor pops and compares whenever load_pc is seen.
// Optional feature macro: BRANCH_UNIT_LINK_EN.
// -----------------------------------------------------------------------------
module tb_branch_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  Z_in;
  logic        loads;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  cond;
  logic [7:0]  imm8;
  logic [8:0]  pc_in;
  logic [8:0]  pc_next;
  logic        load_pc;
  logic        taken;
  logic [2:0]  status;
`ifdef BRANCH_UNIT_LINK_EN
  logic [15:0] link_out;
  logic        link_we;
`endif

  branch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Z_in     (Z_in),
    .loads    (loads),
    .br_valid (br_valid),
    .br_ready (br_ready),
    .cond     (cond),
    .imm8     (imm8),
    .pc_in    (pc_in),
    .pc_next  (pc_next),
    .load_pc  (load_pc),
    .taken    (taken),
    .status   (status)
`ifdef BRANCH_UNIT_LINK_EN
    ,
    .link_out (link_out),
    .link_we  (link_we)
`endif
  );

  typedef struct {
    logic        taken;
    logic [8:0]  pc;
    int          acc;
    logic        lwe;
    logic [15:0] lout;
  } exp_t;

  exp_t sb_q[$];
  int   passed   = 0;
  int   total    = 0;
  int   cyc      = 0;
  int   load_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endfunction

  // Monitor: one line per completed branch.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && load_pc) begin
      load_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_load_pc: got load_pc=1, required 0 (nothing outstanding, cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        $display("branch done: taken=%0b pc_next=0x%03h (expected taken=%0b pc_next=0x%03h)",
                 taken, pc_next, e.taken, e.pc);
        chk("taken", 32'(taken), 32'(e.taken));
        chk("pc_next", 32'(pc_next), 32'(e.pc));
        chk("latency", 32'(cyc - e.acc), 32'd2);
`ifdef BRANCH_UNIT_LINK_EN
        chk("link_we", 32'(link_we), 32'(e.lwe));
        if (e.lwe) chk("link_out", 32'(link_out), 32'(e.lout));
`endif
      end
    end
  end

  task automatic set_status(input logic [2:0] v);
    @(negedge clk);
    loads = 1'b1;
    Z_in  = v;
    @(negedge clk);
    loads = 1'b0;
    chk("status_load", 32'(status), 32'(v));
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] im, input logic [8:0] pc,
                      input logic et, input logic [8:0] epc,
                      input logic ld, input logic [2:0] zin);
    exp_t e;
    int   waited;
    @(negedge clk);
    cond     = c;
    imm8     = im;
    pc_in    = pc;
    br_valid = 1'b1;
    loads    = ld;
    Z_in     = zin;
    waited   = 0;
    while (!br_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!br_ready) begin
      total++;
      $display("FAIL accept_timeout: got br_ready=0, required 1 within 20 cycles");
      br_valid = 1'b0;
      loads    = 1'b0;
      return;
    end
    e.taken = et;
    e.pc    = epc;
    e.acc   = cyc;
    e.lwe   = 1'b0;
`ifdef BRANCH_UNIT_LINK_EN
    e.lwe   = (c == 3'b111);
`endif
    e.lout  = {7'b0, pc};
    sb_q.push_back(e);
    @(negedge clk);
    br_valid = 1'b0;
    loads    = 1'b0;
    waited   = 0;
    while (sb_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      total++;
      $display("FAIL load_pc_timeout: got no load_pc, required one within 10 cycles");
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int loads_before;
    reset    = 1'b1;
    Z_in     = 3'b000;
    loads    = 1'b0;
    br_valid = 1'b0;
    cond     = 3'b000;
    imm8     = 8'h00;
    pc_in    = 9'h000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_load_pc", 32'(load_pc), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);

    // BEQ with Z=1
    set_status(3'b001);
    send(3'b001, 8'h05, 9'h010, 1'b1, 9'h015, 1'b0, 3'b000);
    // BLT: N==V not taken, then N!=V taken
    set_status(3'b000);
    send(3'b011, 8'hFE, 9'h020, 1'b0, 9'h020, 1'b0, 3'b000);
    set_status(3'b010);
    send(3'b011, 8'hFE, 9'h020, 1'b1, 9'h01E, 1'b0, 3'b000);
    // B with wrap-around
    send(3'b000, 8'h02, 9'h1FF, 1'b1, 9'h001, 1'b0, 3'b000);
    send(3'b000, 8'h80, 9'h000, 1'b1, 9'h180, 1'b0, 3'b000);
    // BNE with Z=0
    send(3'b010, 8'h10, 9'h100, 1'b1, 9'h110, 1'b0, 3'b000);
    // BLE taken on Z, BNE not taken on Z
    set_status(3'b001);
    send(3'b100, 8'h7F, 9'h0F0, 1'b1, 9'h16F, 1'b0, 3'b000);
    send(3'b010, 8'h7F, 9'h0F0, 1'b0, 9'h0F0, 1'b0, 3'b000);
    // N=V=1: BLT not taken; reserved codes not taken
    set_status(3'b110);
    send(3'b011, 8'h20, 9'h0A0, 1'b0, 9'h0A0, 1'b0, 3'b000);
    send(3'b101, 8'h04, 9'h0B0, 1'b0, 9'h0B0, 1'b0, 3'b000);
`ifdef BRANCH_UNIT_LINK_EN
    send(3'b111, 8'h08, 9'h0C0, 1'b1, 9'h0C8, 1'b0, 3'b000);
`else
    send(3'b111, 8'h08, 9'h0C0, 1'b0, 9'h0C0, 1'b0, 3'b000);
`endif

    // loads coincident with accept: old status (Z=0) is used
    set_status(3'b000);
    send(3'b001, 8'h04, 9'h030, 1'b0, 9'h030, 1'b1, 3'b001);
    chk("status_after_coincident_load", 32'(status), 32'd1);

    // Reset while in EVAL aborts the branch
    loads_before = load_cnt;
    @(negedge clk);
    cond     = 3'b000;
    imm8     = 8'h02;
    pc_in    = 9'h060;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("abort_load_pc", 32'(load_pc), 32'd0);
    chk("abort_status", 32'(status), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_pulse", 32'(load_cnt), 32'(loads_before));
    chk("abort_br_ready", 32'(br_ready), 32'd1);
    chk("abort_pc_next", 32'(pc_next), 32'd0);
    chk("abort_taken", 32'(taken), 32'd0);
    $display("reset abort: load_pc pulses before=%0d after=%0d", loads_before, load_cnt);

    // Normal operation after reset: BNE with Z=0, negative offset
    send(3'b010, 8'hF0, 9'h050, 1'b1, 9'h040, 1'b0, 3'b000);
`ifdef BRANCH_UNIT_LINK_EN
    send(3'b111, 8'h10, 9'h044, 1'b1, 9'h054, 1'b0, 3'b000);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
